bill_pay_ctrl_gen2: RTL and testbench

Parametrised next-generation anytime electricity bill payment controller. Sequences user login, selects one of N payment channels (card, cheque/DD with MICR check, cash, digital, ...), accumulates partial payments against a programmable due amount, and drives the consumer supply enable. Sits between the kiosk front-end inputs and the meter/supply relay interface.

---
 rtl/bill_pay_pkg.sv | 28 ++
 rtl/pay_accum.sv | 43 ++++
 rtl/bill_pay_ctrl_gen2.sv | 197 +++++++++++++++++++
 tb/tb_bill_pay_ctrl_gen2.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bill_pay_pkg.sv
// Shared types and helpers for the bill payment controller.
// Holds the FSM state encoding, the channel slot numbers and the saturating adder.
package bill_pay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_AUTH     = 3'd2,
    ST_PAY_WAIT = 3'd3,
    ST_SETTLE   = 3'd4
  } state_t;

  localparam int CH_CARD    = 0;
  localparam int CH_DD      = 1;
  localparam int CH_CASH    = 2;
  localparam int CH_DIGITAL = 3;

  // Adds two amounts and clamps the result to the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/pay_accum.sv
// Session payment accumulator: saturating running total, registered balance, settled flag.
// balance trails paid_total by one cycle; settled is derived directly from the running total.
module pay_accum
  import bill_pay_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [AMT_W-1:0] amount,
  input  logic [AMT_W-1:0] due,
  output logic [AMT_W-1:0] paid_total,
  output logic [AMT_W-1:0] balance,
  output logic             settled
);

  logic [AMT_W-1:0] r_paid;
  logic [AMT_W-1:0] r_balance;
  logic [AMT_W-1:0] w_paid_sum;

  assign w_paid_sum = AMT_W'(sat_add(32'(r_paid), 32'(amount), AMT_W));
  assign settled    = (r_paid >= due);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_paid    <= '0;
      r_balance <= '0;
    end else begin
      if (clear) begin
        r_paid <= '0;
      end else if (add_en) begin
        r_paid <= w_paid_sum;
      end
      r_balance <= settled ? '0 : (due - r_paid);
    end
  end

  assign paid_total = r_paid;
  assign balance    = r_balance;

endmodule

// File: rtl/bill_pay_ctrl_gen2.sv
// Kiosk bill payment controller: login with lockout, multi-channel payment intake,
// settlement against the latched due amount and supply relay enable.
module bill_pay_ctrl_gen2
  import bill_pay_pkg::*;
#(
  parameter int AMT_W       = 16,
  parameter int NUM_CH      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int LOCK_CYC    = 5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              login_req,
  input  logic              cred_ok,
  input  logic [AMT_W-1:0]  due_amount,
  input  logic [NUM_CH-1:0] ch_present,
  input  logic [AMT_W-1:0]  ch_amount,
  input  logic              micr_valid,
  input  logic              done_req,
  output logic              authorized,
  output logic              locked,
  output logic [NUM_CH-1:0] ch_active,
  output logic              pay_ack,
  output logic              pay_rej,
  output logic [AMT_W-1:0]  paid_total,
  output logic [AMT_W-1:0]  balance,
  output logic              supply_en
);

  localparam int TRY_W  = ($clog2(MAX_TRIES + 1) > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int LOCK_W = ($clog2(LOCK_CYC) > 0) ? $clog2(LOCK_CYC) : 1;
  localparam int TO_W   = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            r_state, w_state_next;
  logic [TRY_W-1:0]  r_tries, w_tries_next;
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_cnt_next;
  logic [TO_W-1:0]   r_idle_cnt, w_idle_cnt_next;
  logic              r_done_pend, w_done_pend_next;
  logic [AMT_W-1:0]  r_due, w_due_next;
  logic              r_pay_ack, w_pay_ack_next;
  logic              r_pay_rej, w_pay_rej_next;
  logic [NUM_CH-1:0] r_ch_active, w_ch_active_next;
  logic              r_supply_en, w_supply_en_next;

  logic w_accum_clear;
  logic w_add_en;
  logic w_settled;
  logic w_dd_sel;
  logic w_onehot;
  logic w_pay_valid;
  logic w_pay_bad;
  logic w_activity;
  logic w_timeout;

  generate
    if (NUM_CH > CH_DD) begin : g_dd
      assign w_dd_sel = ch_present[CH_DD];
    end else begin : g_no_dd
      assign w_dd_sel = 1'b0;
    end
  endgenerate

  assign w_onehot    = (ch_present != '0) && ((ch_present & (ch_present - 1'b1)) == '0);
  assign w_pay_valid = w_onehot && !(w_dd_sel && !micr_valid) && (ch_amount != '0);
  assign w_pay_bad   = (ch_present != '0) && !w_pay_valid;
  assign w_activity  = login_req || done_req || (ch_present != '0);
  assign w_timeout   = !w_activity && (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tries     <= '0;
      r_lock_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_done_pend <= 1'b0;
      r_due       <= '0;
      r_pay_ack   <= 1'b0;
      r_pay_rej   <= 1'b0;
      r_ch_active <= '0;
      r_supply_en <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_tries     <= w_tries_next;
      r_lock_cnt  <= w_lock_cnt_next;
      r_idle_cnt  <= w_idle_cnt_next;
      r_done_pend <= w_done_pend_next;
      r_due       <= w_due_next;
      r_pay_ack   <= w_pay_ack_next;
      r_pay_rej   <= w_pay_rej_next;
      r_ch_active <= w_ch_active_next;
      r_supply_en <= w_supply_en_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_tries_next     = r_tries;
    w_lock_cnt_next  = '0;
    w_idle_cnt_next  = '0;
    w_done_pend_next = 1'b0;
    w_due_next       = r_due;
    w_pay_ack_next   = 1'b0;
    w_pay_rej_next   = 1'b0;
    w_ch_active_next = '0;
    w_supply_en_next = r_supply_en;
    w_accum_clear    = 1'b0;
    w_add_en         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (login_req) begin
          if (cred_ok) begin
            w_state_next  = ST_AUTH;
            w_due_next    = due_amount;
            w_accum_clear = 1'b1;
            w_tries_next  = '0;
          end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
            w_state_next = ST_LOCKED;
            w_tries_next = '0;
          end else begin
            w_tries_next = r_tries + 1'b1;
          end
        end
      end

      ST_LOCKED: begin
        if (r_lock_cnt == LOCK_W'(LOCK_CYC - 1)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_lock_cnt_next = r_lock_cnt + 1'b1;
        end
      end

      ST_AUTH: begin
        w_state_next = w_settled ? ST_SETTLE : ST_PAY_WAIT;
      end

      ST_PAY_WAIT: begin
        // A payment arriving with done/timeout is booked first; the session closes next cycle.
        if (r_done_pend) begin
          w_state_next     = ST_IDLE;
          w_supply_en_next = w_settled;
        end else if (w_settled) begin
          w_state_next = ST_SETTLE;
        end else begin
          w_idle_cnt_next = w_activity ? '0 : (r_idle_cnt + 1'b1);
          if (w_pay_valid) begin
            w_pay_ack_next   = 1'b1;
            w_ch_active_next = ch_present;
            w_add_en         = 1'b1;
            w_done_pend_next = done_req;
          end else begin
            w_pay_rej_next = w_pay_bad;
            if (done_req || w_timeout) begin
              w_state_next     = ST_IDLE;
              w_supply_en_next = w_settled;
            end
          end
        end
      end

      ST_SETTLE: begin
        w_state_next = ST_IDLE;
        if (w_settled) begin
          w_supply_en_next = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  pay_accum #(
    .AMT_W(AMT_W)
  ) u_pay_accum (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_accum_clear),
    .add_en     (w_add_en),
    .amount     (ch_amount),
    .due        (r_due),
    .paid_total (paid_total),
    .balance    (balance),
    .settled    (w_settled)
  );

  assign authorized = (r_state == ST_AUTH) || (r_state == ST_PAY_WAIT) || (r_state == ST_SETTLE);
  assign locked     = (r_state == ST_LOCKED);
  assign ch_active  = r_ch_active;
  assign pay_ack    = r_pay_ack;
  assign pay_rej    = r_pay_rej;
  assign supply_en  = r_supply_en;

endmodule

// File: tb/tb_bill_pay_ctrl_gen2.sv
// Directed bench for bill_pay_ctrl_gen2: lockout, payment channels, settlement,
// timeout, simultaneous done/payment and asynchronous reset mid-session.
module tb_bill_pay_ctrl_gen2;

  localparam int AMT_W  = 16;
  localparam int NUM_CH = 4;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              login_req  = 1'b0;
  logic              cred_ok    = 1'b0;
  logic [AMT_W-1:0]  due_amount = '0;
  logic [NUM_CH-1:0] ch_present = '0;
  logic [AMT_W-1:0]  ch_amount  = '0;
  logic              micr_valid = 1'b0;
  logic              done_req   = 1'b0;
  logic              authorized;
  logic              locked;
  logic [NUM_CH-1:0] ch_active;
  logic              pay_ack;
  logic              pay_rej;
  logic [AMT_W-1:0]  paid_total;
  logic [AMT_W-1:0]  balance;
  logic              supply_en;

  int n_checks = 0;
  int n_errors = 0;

  bill_pay_ctrl_gen2 #(
    .AMT_W(AMT_W), .NUM_CH(NUM_CH), .MAX_TRIES(3), .TIMEOUT_CYC(1000), .LOCK_CYC(5000)
  ) dut (
    .clk(clk), .reset(reset), .login_req(login_req), .cred_ok(cred_ok),
    .due_amount(due_amount), .ch_present(ch_present), .ch_amount(ch_amount),
    .micr_valid(micr_valid), .done_req(done_req), .authorized(authorized),
    .locked(locked), .ch_active(ch_active), .pay_ack(pay_ack), .pay_rej(pay_rej),
    .paid_total(paid_total), .balance(balance), .supply_en(supply_en)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic login(input logic ok, input int due);
    login_req  = 1'b1;
    cred_ok    = ok;
    due_amount = AMT_W'(due);
    step();
    login_req  = 1'b0;
    cred_ok    = 1'b0;
    $display("txn login ok=%0b due=%0d", ok, due);
  endtask

  task automatic login_ok(input int due);
    login(1'b1, due);
    check("auth_on_login", 32'(authorized), 1);
    step();
  endtask

  task automatic pay(input logic [NUM_CH-1:0] ch, input int amt, input logic micr,
                     input logic done);
    ch_present = ch;
    ch_amount  = AMT_W'(amt);
    micr_valid = micr;
    done_req   = done;
    step();
    ch_present = '0;
    ch_amount  = '0;
    micr_valid = 1'b0;
    done_req   = 1'b0;
    $display("txn pay ch=%b amt=%0d micr=%0b done=%0b ack=%0b rej=%0b paid=%0d",
             ch, amt, micr, done, pay_ack, pay_rej, paid_total);
  endtask

  task automatic end_session();
    done_req = 1'b1;
    step();
    done_req = 1'b0;
    $display("txn done supply_en=%0b", supply_en);
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_auth", 32'(authorized), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_supply", 32'(supply_en), 1);
    check("rst_paid", 32'(paid_total), 0);
    check("rst_balance", 32'(balance), 0);
    check("rst_ack", 32'(pay_ack), 0);
    check("rst_rej", 32'(pay_rej), 0);
    check("rst_ch_active", 32'(ch_active), 0);
    reset = 1'b0;
    step();

    // Three bad logins lock the kiosk for 5000 cycles
    login(1'b0, 0);
    step();
    login(1'b0, 0);
    check("locked_after2", 32'(locked), 0);
    step();
    login(1'b0, 0);
    check("locked_after3", 32'(locked), 1);
    login(1'b1, 50);
    check("lock_ignores_login", 32'(authorized), 0);
    check("lock_still", 32'(locked), 1);
    step(4985);
    check("lock_near_end", 32'(locked), 1);
    step(20);
    check("lock_released", 32'(locked), 0);

    // MICR failure on the DD channel, then done with balance outstanding
    login_ok(100);
    pay(4'b0010, 50, 1'b0, 1'b0);
    check("micr_rej", 32'(pay_rej), 1);
    check("micr_no_ack", 32'(pay_ack), 0);
    check("micr_paid", 32'(paid_total), 0);
    check("micr_balance", 32'(balance), 100);
    end_session();
    check("micr_supply_off", 32'(supply_en), 0);
    check("micr_logout", 32'(authorized), 0);

    // Card pays the full 100
    login_ok(100);
    pay(4'b0001, 100, 1'b0, 1'b0);
    check("card_ack", 32'(pay_ack), 1);
    check("card_ch_active", 32'(ch_active), 1);
    check("card_paid", 32'(paid_total), 100);
    step();
    check("card_settle_balance", 32'(balance), 0);
    check("card_settle_auth", 32'(authorized), 1);
    check("card_ack_pulse", 32'(pay_ack), 0);
    step();
    check("card_supply_on", 32'(supply_en), 1);
    check("card_logout", 32'(authorized), 0);
    check("card_paid_held", 32'(paid_total), 100);

    // Done with nothing paid switches supply off
    login_ok(100);
    check("relogin_paid_clr", 32'(paid_total), 0);
    end_session();
    check("nopay_supply_off", 32'(supply_en), 0);

    // Cash 40 then digital 70 overpays
    login_ok(100);
    pay(4'b0100, 40, 1'b0, 1'b0);
    check("cash_ack", 32'(pay_ack), 1);
    check("cash_paid", 32'(paid_total), 40);
    step();
    check("cash_balance", 32'(balance), 60);
    pay(4'b1000, 70, 1'b0, 1'b0);
    check("dig_ack", 32'(pay_ack), 1);
    check("dig_ch_active", 32'(ch_active), 8);
    check("dig_paid", 32'(paid_total), 110);
    step();
    check("dig_balance", 32'(balance), 0);
    step();
    check("dig_supply_on", 32'(supply_en), 1);

    // Non-one-hot strobe rejected, then session times out
    login_ok(200);
    pay(4'b0101, 10, 1'b1, 1'b0);
    check("multi_rej", 32'(pay_rej), 1);
    check("multi_no_ack", 32'(pay_ack), 0);
    step(989);
    check("to_before", 32'(authorized), 1);
    step(20);
    check("to_after_auth", 32'(authorized), 0);
    check("to_supply_off", 32'(supply_en), 0);

    // Zero due settles straight from login
    login(1'b1, 0);
    step();
    check("due0_settle_auth", 32'(authorized), 1);
    step();
    check("due0_supply_on", 32'(supply_en), 1);
    check("due0_logout", 32'(authorized), 0);

    // Payment and done in the same cycle: payment first, then logout
    login_ok(100);
    end_session();
    check("pre_sim_supply_off", 32'(supply_en), 0);
    login_ok(100);
    pay(4'b0001, 100, 1'b0, 1'b1);
    check("sim_ack", 32'(pay_ack), 1);
    check("sim_paid", 32'(paid_total), 100);
    step();
    check("sim_logout", 32'(authorized), 0);
    check("sim_supply_on", 32'(supply_en), 1);

    // Asynchronous reset in the middle of PAY_WAIT
    login_ok(30);
    end_session();
    login_ok(30);
    pay(4'b0100, 10, 1'b0, 1'b0);
    check("pre_rst_paid", 32'(paid_total), 10);
    check("pre_rst_supply", 32'(supply_en), 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_auth", 32'(authorized), 0);
    check("arst_supply", 32'(supply_en), 1);
    check("arst_paid", 32'(paid_total), 0);
    check("arst_ack", 32'(pay_ack), 0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_auth", 32'(authorized), 0);
    check("post_rst_supply", 32'(supply_en), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
